// File: rtl/vga_pkg.sv
// Timing constants for the 640x480@60 Hz raster controller.
// Holds the default region lengths, the derived totals and sync
// boundaries, and the counter type shared by the controller files.
package vga_pkg;

  localparam int VGA_CLK_DIV   = 4;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam int VGA_H_SYNC_WIDTH = VGA_H_SYNC;
  localparam int VGA_V_SYNC_WIDTH = VGA_V_SYNC;

  typedef logic [9:0] cnt_t;

  // Converts a region boundary (in pixels or lines) to counter width.
  function automatic cnt_t to_cnt(input int value);
    return cnt_t'(value);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_pixel_tick_gen.sv
// pixel_tick_gen: clock-enable divider producing the pixel rate.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   en      in  run enable; low freezes the divider
//   tick    out high during the last system clock of each pixel period
// CLK_DIV must be at least 2.
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  // Combinational so the counters see the tick in the same clock the
  // divider reaches its last count.
  assign tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster timing generator for 640x480@60 Hz VGA.
// Ports:
//   clk         in  system clock (100 MHz)
//   reset_n     in  asynchronous active-low reset
//   en          in  run enable; low freezes divider, counters, outputs
//   p_tick      out one-clk pulse on the first clock of each new pixel
//   h_sync      out horizontal sync, active-low
//   v_sync      out vertical sync, active-low
//   DE          out display enable (visible area)
//   x_pixel     out horizontal position of the presented pixel
//   y_pixel     out vertical position of the presented pixel
//   line_start  out one-clk pulse when x_pixel becomes 0
//   frame_start out one-clk pulse when (x_pixel, y_pixel) becomes (0,0)
//   frame_cnt   out 16-bit frame counter (only with VGA_FRAME_CNT_EN)
// Optional feature macro: VGA_FRAME_CNT_EN adds the frame_cnt port.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic       p_tick,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam cnt_t H_LAST     = to_cnt(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST     = to_cnt(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS      = to_cnt(H_VISIBLE);
  localparam cnt_t V_VIS      = to_cnt(V_VISIBLE);
  localparam cnt_t HS_FIRST   = to_cnt(H_VISIBLE + H_FP);
  localparam cnt_t HS_LAST    = to_cnt(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST   = to_cnt(V_VISIBLE + V_FP);
  localparam cnt_t VS_LAST    = to_cnt(V_VISIBLE + V_FP + V_SYNC - 1);

  logic tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_zero;
  logic v_zero;
  logic hs_active;
  logic vs_active;
  logic de_next;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick)
  );

  // Decode of the pre-increment counters; the output registers load this,
  // so every output lags h_cnt/v_cnt by one pixel.
  assign h_zero    = (h_cnt == '0);
  assign v_zero    = (v_cnt == '0);
  assign hs_active = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_active = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign de_next   = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      DE          <= 1'b0;
      p_tick      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      p_tick      <= tick;
      line_start  <= tick && h_zero;
      frame_start <= tick && h_zero && v_zero;
      if (tick) begin
        x_pixel <= h_cnt;
        y_pixel <= v_cnt;
        h_sync  <= !hs_active;
        v_sync  <= !vs_active;
        DE      <= de_next;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Advances on the same edge that raises frame_start; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (tick && h_zero && v_zero) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  localparam int CLK_DIV = 4;
  localparam int HT      = 800;
  localparam int V_VIS   = 4;
  localparam int V_FPL   = 2;
  localparam int V_SYN   = 2;
  localparam int V_BPL   = 1;
  localparam int VT      = V_VIS + V_FPL + V_SYN + V_BPL;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        pt;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    string nm;
    logic  e;
    int    cyc;
    exp_t  ex;
  } seg_t;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        p_tick;
  logic        h_sync;
  logic        v_sync;
  logic        de;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        line_start;
  logic        frame_start;
  logic [15:0] fc_act;

  int tests_run;
  int tests_failed;
  int n;
  exp_t sb[$];
  seg_t segs[$];

  vga_timing_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .V_VISIBLE (V_VIS),
    .V_FP      (V_FPL),
    .V_SYNC    (V_SYN),
    .V_BP      (V_BPL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .p_tick      (p_tick),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .DE          (de),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_act)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_act = 16'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input int x, input int y, input bit d, input bit hs, input bit vs,
                              input bit pt, input bit ls, input bit fs, input int fc);
    exp_t r;
    r.x  = 10'(x);
    r.y  = 10'(y);
    r.de = d;
    r.hs = hs;
    r.vs = vs;
    r.pt = pt;
    r.ls = ls;
    r.fs = fs;
    r.fc = 16'(fc);
    return r;
  endfunction

  // Expected outputs after `cnt` enabled edges since reset release; `e`
  // is the enable seen at the most recent edge.
  function automatic exp_t model(input int cnt, input logic e);
    int p;
    int x;
    int y;
    bit pt;
    if (cnt < CLK_DIV) return mk(0, 0, 0, 1, 1, 0, 0, 0, 0);
    p  = cnt / CLK_DIV - 1;
    x  = p % HT;
    y  = (p / HT) % VT;
    pt = e && (cnt % CLK_DIV == 0);
    return mk(x, y, (x < 640) && (y < V_VIS), !(x >= 656 && x <= 751),
              !(y >= V_VIS + V_FPL && y < V_VIS + V_FPL + V_SYN),
              pt, pt && x == 0, pt && x == 0 && y == 0, p / (HT * VT) + 1);
  endfunction

  task automatic cmp(input string name, input exp_t ex);
    exp_t got;
    exp_t want;
    got.x  = x_pixel;
    got.y  = y_pixel;
    got.de = de;
    got.hs = h_sync;
    got.vs = v_sync;
    got.pt = p_tick;
    got.ls = line_start;
    got.fs = frame_start;
    got.fc = fc_act;
    want   = ex;
`ifndef VGA_FRAME_CNT_EN
    want.fc = 16'd0;
`endif
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s n=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b pt=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b pt=%b ls=%b fs=%b fc=%0d",
               name, n, got.x, got.y, got.de, got.hs, got.vs, got.pt, got.ls, got.fs, got.fc,
               want.x, want.y, want.de, want.hs, want.vs, want.pt, want.ls, want.fs, want.fc);
    end
  endtask

  task automatic step(input logic e);
    exp_t ex;
    en = e;
    @(posedge clk);
    if (e) n++;
    sb.push_back(model(n, e));
    @(negedge clk);
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard: queue empty at n=%0d", n);
    end else begin
      ex = sb.pop_front();
      cmp("cycle", ex);
    end
  endtask

  task automatic add_seg(input string nm, input logic e, input int cyc, input exp_t ex);
    seg_t s;
    s.nm  = nm;
    s.e   = e;
    s.cyc = cyc;
    s.ex  = ex;
    segs.push_back(s);
  endtask

  task automatic run_segs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      repeat (segs[i].cyc) step(segs[i].e);
      cmp(segs[i].nm, segs[i].ex);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n            = 0;
    en           = 1'b1;
    reset_n      = 1'b0;

    //       name          en   cycles  x    y  de hs vs pt ls fs fc
    add_seg("first_pixel", 1,      4, mk(  0, 0, 1, 1, 1, 1, 1, 1, 1));
    add_seg("pre_pause",   1,   1202, mk(300, 0, 1, 1, 1, 0, 0, 0, 1));
    add_seg("pause",       0,     37, mk(300, 0, 1, 1, 1, 0, 0, 0, 1));
    add_seg("resume_a",    1,      1, mk(300, 0, 1, 1, 1, 0, 0, 0, 1));
    add_seg("resume_b",    1,      1, mk(301, 0, 1, 1, 1, 1, 0, 0, 1));
    add_seg("hs_before",   1,   1416, mk(655, 0, 0, 1, 1, 1, 0, 0, 1));
    add_seg("hs_fall",     1,      4, mk(656, 0, 0, 0, 1, 1, 0, 0, 1));
    add_seg("hs_last",     1,    380, mk(751, 0, 0, 0, 1, 1, 0, 0, 1));
    add_seg("hs_rise",     1,      4, mk(752, 0, 0, 1, 1, 1, 0, 0, 1));
    add_seg("line1",       1,    192, mk(  0, 1, 1, 1, 1, 1, 1, 0, 1));
    add_seg("vs_low",      1,  16000, mk(  0, 6, 0, 1, 0, 1, 1, 0, 1));
    add_seg("vs_last",     1,   6396, mk(799, 7, 0, 1, 0, 1, 0, 0, 1));
    add_seg("vs_rise",     1,      4, mk(  0, 8, 0, 1, 1, 1, 1, 0, 1));
    add_seg("frame_end",   1,   3196, mk(799, 8, 0, 1, 1, 1, 0, 0, 1));
    add_seg("frame_wrap",  1,      4, mk(  0, 0, 1, 1, 1, 1, 1, 1, 2));
    add_seg("frame2_pre",  1,  28799, mk(799, 8, 0, 1, 1, 0, 0, 0, 2));
    add_seg("frame3",      1,      1, mk(  0, 0, 1, 1, 1, 1, 1, 1, 3));
    add_seg("mid_frame",   1,   8000, mk(400, 2, 1, 1, 1, 1, 0, 0, 3));
    add_seg("rst_first",   1,      3, mk(  0, 0, 0, 1, 1, 0, 0, 0, 0));
    add_seg("rst_tick",    1,      1, mk(  0, 0, 1, 1, 1, 1, 1, 1, 1));

    repeat (3) @(negedge clk);
    cmp("reset_state", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    reset_n = 1'b1;

    run_segs(0, 17);

    // Mid-pixel at (400,2): reset must clear outputs without waiting for a clock.
    step(1'b1);
    step(1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("async_reset", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    cmp("reset_hold", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    reset_n = 1'b1;
    n = 0;

    run_segs(18, 19);
    repeat (8) step(1'b1);

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
